data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Data-memory responder: the slave end of the memory-stage load/store interface.
- Accepts one request per transaction: request, we_re, 4-bit byte mask, address and store data. Holds it for a programmable access latency, then commits the masked write or returns the full read word with a one-cycle data_valid pulse.
- Sits between the core's memory stage and on-chip data SRAM. Byte-lane extraction and sign extension of loads stay in the core's load wrapper.

Parameters:
- DataWidth, 32, data and address width (only 32 supported).
- Depth, 1024, memory size in 32-bit words (power of two).
- Latency, 1, cycles from request acceptance to response (legal range 1..15).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- request  input  1  transaction request from memory stage.
- we_re  input  1  1 = store, 0 = load; sampled with request.
- mask  input  4  byte-lane write enables; bit i covers bits [8i+7:8i].
- address  input  DataWidth  byte address; word index = address[$clog2(Depth)+1:2], bits [1:0] ignored.
- store_data_in  input  DataWidth  lane-aligned store data.
- ready  output  1  responder idle and able to accept a request.
- data_valid  output  1  one-cycle response pulse (load or store completion).
- load_data_out  output  DataWidth  full read word; valid when data_valid=1 on a load.
- err  output  1  out-of-range access; valid only with data_valid.

Behaviour:
- Reset:
  - state=IDLE, ready=1, data_valid=0, err=0, load_data_out=0, latency counter=0.
  - Memory array is NOT cleared.
  - Reset takes priority over all other events.
- States: IDLE, WAIT.
- IDLE:
  - ready=1.
  - If request=1 at edge k: capture we_re, mask, word index, store_data_in, and an out-of-range flag (address >= 4*Depth).
  - Load counter with Latency-1 and go to WAIT.
  - request=0 leaves the block in IDLE.
- WAIT:
  - ready=0; request is ignored (not queued).
  - Counter decrements each edge.
  - At the edge where counter==0, i.e. edge k+Latency:
    - Perform the access.
    - Register data_valid=1.
    - Return to IDLE.
- Store access:
  - For each i with mask[i]=1, write mem[idx] byte i from the captured data.
  - Other bytes are unchanged. mask=0000 writes nothing but still completes.
  - load_data_out=0 in the response cycle.
- Load access:
  - load_data_out=mem[idx] (full word, mask ignored).
  - If the same word was written by an earlier completed store, the new value is returned.
- Out of range:
  - Store is dropped (memory unchanged).
  - Load returns 0.
  - err=1 for the same single cycle as data_valid.
- Pulse timing:
  - data_valid and err are high exactly one cycle, then return to 0.
  - load_data_out holds its value until the next response.
- Throughput:
  - Earliest next acceptance is edge k+Latency+1.
  - That is one transaction per Latency+1 cycles.
  - ready is high during the data_valid cycle.
- Input stability: inputs need only be valid at the accepting edge. Changes during WAIT have no effect.
- Reset mid-operation: the transaction is abandoned, no write is committed, no data_valid is produced.

Test Plan:
- Reset, then store word: request=1, we_re=1, mask=1111, address=0x10, data=0xDEADBEEF. Then load 0x10 -> load_data_out=0xDEADBEEF, data_valid exactly 1 cycle at edge k+Latency, err=0.
- Byte-masked store: preload 0x11223344 at 0x20, store mask=0100 data=0x00AA0000 -> load 0x20 returns 0x11AA3344. Repeat with mask=0000 -> word unchanged, data_valid still pulses.
- Latency=3 with request held high continuously -> acceptances at edges 0, 4, 8. data_valid at edges 3, 7, 11. ready low for 3 cycles after each acceptance.
- Out-of-range: Depth=1024, store to 0x1000 then load 0x1000 -> err=1 with data_valid on both, load_data_out=0. No aliasing into word 0: word 0 keeps its prior value.
- Low address bits ignored: store 0xCAFEF00D at 0x43, load 0x40 -> 0xCAFEF00D.
- Reset during WAIT: Latency=4, store 0x55555555 to 0x8 (word previously 0x0), assert rst one cycle after acceptance -> no data_valid, ready=1. Subsequent load of 0x8 returns 0x0.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with programmable access latency
// Accepts one load/store, waits Latency cycles, then commits the write or returns the read word.
module data_mem_responder #(
    parameter int DataWidth = 32,
    parameter int Depth     = 1024,
    parameter int Latency   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 request,
    input  logic                 we_re,
    input  logic [3:0]           mask,
    input  logic [DataWidth-1:0] address,
    input  logic [DataWidth-1:0] store_data_in,
    output logic                 ready,
    output logic                 data_valid,
    output logic [DataWidth-1:0] load_data_out,
    output logic                 err
);
    localparam int AW = $clog2(Depth);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [3:0]           mask_q, mask_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 oor_q, oor_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 access;
    logic                 unused_addr_bits;

    logic [DataWidth-1:0] mem_q [Depth];

    // Byte offset bits never select anything; the core's load wrapper handles lanes.
    assign unused_addr_bits = ^address[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (request) begin
                    we_d    = we_re;
                    mask_d  = mask;
                    idx_d   = address[AW+1:2];
                    wdata_d = store_data_in;
                    oor_d   = |address[DataWidth-1:AW+2];
                    cnt_d   = 4'(Latency - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    valid_d = 1'b1;
                    err_d   = oor_q;
                    rdata_d = (we_q || oor_q) ? '0 : mem_q[idx_q];
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            mask_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is deliberately not reset; an abandoned transaction never reaches this write.
    always_ff @(posedge clk) begin
        if (!rst && access && we_q && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ready         = (state_q == IDLE);
    assign data_valid    = valid_q;
    assign err           = err_q;
    assign load_data_out = rdata_q;
endmodule
